// File: rtl/wb_regfile.sv
// RV32I writeback stage: selects/extends the writeback value, commits it to the
// 32x32 integer register file with bypassed read ports, a load-wait stall, an
// instret counter and a registered commit trace.
module wb_regfile #(
    parameter int RESET_PC_UNUSED = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic        sig_regwrite,
    input  logic [2:0]  sig_regwrsrc,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    input  logic [2:0]  load_funct3,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] imm,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic        wb_stall,
    output logic        trace_valid,
    output logic [4:0]  trace_rd,
    output logic [31:0] trace_data,
    output logic [63:0] instret
);

    localparam logic [2:0] REGWRSRC_ALU    = 3'd0;
    localparam logic [2:0] REGWRSRC_MEM    = 3'd1;
    localparam logic [2:0] REGWRSRC_PC4    = 3'd2;
    localparam logic [2:0] REGWRSRC_IMM    = 3'd3;
    localparam logic [2:0] REGWRSRC_UNUSED = 3'd4;

    // Reserved parameter; it has no effect on the hardware.
    if (RESET_PC_UNUSED != 0) begin : g_reserved
    end

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  ofs,
                                                input logic [2:0]  funct3);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b = word[8*ofs +: 8];
        lane_h = ofs[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  load_extend = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_extend = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_extend = {24'd0, lane_b};
            3'b101:  load_extend = {16'd0, lane_h};
            default: load_extend = word;
        endcase
    endfunction

    logic [31:0] regs [1:31];
    logic [31:0] wb_data_p0;
    logic        commit_p0;
    logic        wr_en_p0;

    // ---- stage p0: writeback select, stall and commit decision
    always_comb begin
        wb_data_p0 = 32'd0;
        case (sig_regwrsrc)
            REGWRSRC_ALU:    wb_data_p0 = alu_result;
            REGWRSRC_MEM:    wb_data_p0 = load_extend(mem_rdata, alu_result[1:0], load_funct3);
            REGWRSRC_PC4:    wb_data_p0 = pc_plus4;
            REGWRSRC_IMM:    wb_data_p0 = imm;
            REGWRSRC_UNUSED: wb_data_p0 = 32'd0;
            default:         wb_data_p0 = 32'd0;
        endcase
    end

    assign wb_stall  = wb_valid & sig_regwrite & (sig_regwrsrc == REGWRSRC_MEM) & ~mem_rvalid;
    assign commit_p0 = wb_valid & ~wb_stall;
    assign wr_en_p0  = commit_p0 & sig_regwrite & (wb_rd != 5'd0);

    // Read ports bypass the value being written this cycle.
    always_comb begin
        rs1_data = 32'd0;
        rs2_data = 32'd0;
        if (rs1_addr != 5'd0)
            rs1_data = (wr_en_p0 && rs1_addr == wb_rd) ? wb_data_p0 : regs[rs1_addr];
        if (rs2_addr != 5'd0)
            rs2_data = (wr_en_p0 && rs2_addr == wb_rd) ? wb_data_p0 : regs[rs2_addr];
    end

    // ---- stage p1: architectural state, counter and commit trace
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < 32; i++)
                regs[i] <= 32'd0;
            instret     <= 64'd0;
            trace_valid <= 1'b0;
            trace_rd    <= 5'd0;
            trace_data  <= 32'd0;
        end else begin
            if (wr_en_p0)
                regs[wb_rd] <= wb_data_p0;
            if (commit_p0)
                instret <= instret + 64'd1;
            trace_valid <= wr_en_p0;
            trace_rd    <= wb_rd;
            trace_data  <= wb_data_p0;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized + directed bench for wb_regfile: a spec-level model predicts read
// ports per cycle and queues the registered trace/instret expected after each edge.
module tb_wb_regfile;

    localparam logic [2:0] SRC_ALU = 3'd0, SRC_MEM = 3'd1, SRC_PC4 = 3'd2,
                           SRC_IMM = 3'd3, SRC_UNU = 3'd4;

    logic        clk, rst, wb_valid, sig_regwrite, mem_rvalid;
    logic [2:0]  sig_regwrsrc, load_funct3;
    logic [4:0]  wb_rd, rs1_addr, rs2_addr, trace_rd;
    logic [31:0] alu_result, mem_rdata, pc_plus4, imm, rs1_data, rs2_data, trace_data;
    logic        wb_stall, trace_valid;
    logic [63:0] instret;

    wb_regfile #(.RESET_PC_UNUSED(0)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .sig_regwrite(sig_regwrite),
        .sig_regwrsrc(sig_regwrsrc), .wb_rd(wb_rd), .alu_result(alu_result),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .load_funct3(load_funct3),
        .pc_plus4(pc_plus4), .imm(imm), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_stall(wb_stall),
        .trace_valid(trace_valid), .trace_rd(trace_rd), .trace_data(trace_data),
        .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v, rw, rv;
        logic [2:0]  src, f3;
        logic [4:0]  rd, a1, a2;
        logic [31:0] alu, mem, pc4, im;
    } stim_t;

    typedef struct {
        logic        tv;
        logic [4:0]  trd;
        logic [31:0] tdata;
        logic [63:0] ir;
    } exp_t;

    exp_t        q[$];
    logic [31:0] marr [32];
    logic [63:0] m_instret;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(input logic v, input logic rw, input logic [2:0] src,
                                 input logic [4:0] rd, input logic [31:0] alu,
                                 input logic [31:0] mem, input logic rv, input logic [2:0] f3,
                                 input logic [4:0] a1, input logic [4:0] a2);
        stim_t s;
        s.v = v; s.rw = rw; s.src = src; s.rd = rd; s.alu = alu; s.mem = mem;
        s.rv = rv; s.f3 = f3; s.a1 = a1; s.a2 = a2;
        s.pc4 = 32'h0000_4004; s.im = 32'hABCD_E000;
        return s;
    endfunction

    // Reference writeback value straight from the selection/extension rules.
    function automatic logic [31:0] ref_wb(input stim_t s);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = s.mem >> (8 * s.alu[1:0]);
        b  = sh[7:0];
        sh = s.mem >> (16 * s.alu[1]);
        h  = sh[15:0];
        case (s.src)
            SRC_ALU: return s.alu;
            SRC_PC4: return s.pc4;
            SRC_IMM: return s.im;
            SRC_MEM:
                case (s.f3)
                    3'b000:  return {{24{b[7]}}, b};
                    3'b001:  return {{16{h[15]}}, h};
                    3'b100:  return {24'd0, b};
                    3'b101:  return {16'd0, h};
                    default: return s.mem;
                endcase
            default: return 32'd0;
        endcase
    endfunction

    task automatic step(input stim_t s);
        logic [31:0] wbv, e1, e2;
        logic        stall, commit, we;
        exp_t        e;
        @(negedge clk);
        wb_valid = s.v; sig_regwrite = s.rw; sig_regwrsrc = s.src; wb_rd = s.rd;
        alu_result = s.alu; mem_rdata = s.mem; mem_rvalid = s.rv; load_funct3 = s.f3;
        pc_plus4 = s.pc4; imm = s.im; rs1_addr = s.a1; rs2_addr = s.a2;
        #2;
        wbv    = ref_wb(s);
        stall  = s.v && s.rw && (s.src == SRC_MEM) && !s.rv;
        commit = s.v && !stall;
        we     = commit && s.rw && (s.rd != 5'd0);
        e1 = (s.a1 == 5'd0) ? 32'd0 : (we && s.a1 == s.rd) ? wbv : marr[s.a1];
        e2 = (s.a2 == 5'd0) ? 32'd0 : (we && s.a2 == s.rd) ? wbv : marr[s.a2];
        check("wb_stall", {63'd0, wb_stall}, {63'd0, stall});
        check("rs1_data", {32'd0, rs1_data}, {32'd0, e1});
        check("rs2_data", {32'd0, rs2_data}, {32'd0, e2});
        if (commit) m_instret = m_instret + 64'd1;
        if (we) marr[s.rd] = wbv;
        e.tv = we; e.trd = s.rd; e.tdata = wbv; e.ir = m_instret;
        q.push_back(e);
    endtask

    // Monitor: after every edge that followed a driven cycle, compare registered outputs.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            check("trace_valid", {63'd0, trace_valid}, {63'd0, e.tv});
            check("trace_rd",    {59'd0, trace_rd},    {59'd0, e.trd});
            check("trace_data",  {32'd0, trace_data},  {32'd0, e.tdata});
            check("instret",     instret,              e.ir);
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) marr[i] = 32'd0;
        m_instret = 64'd0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rs1"},   {32'd0, rs1_data},   64'd0);
        check({tag, "_rs2"},   {32'd0, rs2_data},   64'd0);
        check({tag, "_tv"},    {63'd0, trace_valid}, 64'd0);
        check({tag, "_trd"},   {59'd0, trace_rd},   64'd0);
        check({tag, "_tdata"}, {32'd0, trace_data}, 64'd0);
        check({tag, "_instret"}, instret, 64'd0);
    endtask

    task automatic go_idle();
        @(posedge clk);
        #3;
        wb_valid = 1'b0;
    endtask

    initial begin
        stim_t cur;
        logic  held;
        logic [31:0] ld;
        wb_valid = 0; sig_regwrite = 0; sig_regwrsrc = SRC_ALU; wb_rd = 0;
        alu_result = 0; mem_rdata = 0; mem_rvalid = 0; load_funct3 = 0;
        pc_plus4 = 0; imm = 0; rs1_addr = 5; rs2_addr = 7;
        model_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // ALU write with same-cycle bypass, then the array read the next cycle
        step(mk(1, 1, SRC_ALU, 7, 32'h1234_5678, 0, 1, 0, 7, 0));
        step(mk(0, 0, SRC_ALU, 0, 0, 0, 1, 0, 7, 7));

        // Load extension across offsets and funct3
        ld = 32'h80FF_7F01;
        step(mk(1, 1, SRC_MEM, 10, 32'h100 | 32'd1, ld, 1, 3'b000, 10, 0));
        step(mk(1, 1, SRC_MEM, 11, 32'h100 | 32'd2, ld, 1, 3'b000, 11, 10));
        step(mk(1, 1, SRC_MEM, 12, 32'h100 | 32'd3, ld, 1, 3'b100, 12, 11));
        step(mk(1, 1, SRC_MEM, 13, 32'h100 | 32'd2, ld, 1, 3'b001, 13, 12));
        step(mk(1, 1, SRC_MEM, 14, 32'h100 | 32'd0, ld, 1, 3'b101, 14, 13));
        step(mk(0, 0, SRC_ALU, 0, 0, 0, 1, 0, 14, 10));

        // Load wait: three stalled cycles then data arrives
        for (int i = 0; i < 3; i++)
            step(mk(1, 1, SRC_MEM, 3, 32'h200, 32'h0, 0, 3'b010, 3, 7));
        step(mk(1, 1, SRC_MEM, 3, 32'h200, 32'hDEAD_BEEF, 1, 3'b010, 3, 7));
        step(mk(0, 0, SRC_ALU, 0, 0, 0, 1, 0, 3, 0));

        // x0 write with x0 read, then a bubble that would otherwise write x9
        step(mk(1, 1, SRC_PC4, 0, 0, 0, 1, 0, 0, 7));
        step(mk(0, 1, SRC_ALU, 9, 32'h5555_AAAA, 0, 0, 0, 9, 0));
        step(mk(0, 1, SRC_MEM, 9, 32'h5555_AAAA, 0, 0, 0, 9, 0));
        step(mk(1, 1, SRC_UNU, 15, 32'h1, 32'h2, 1, 0, 15, 0));
        step(mk(1, 1, SRC_IMM, 16, 32'h1, 32'h2, 1, 0, 16, 15));

        // Random traffic honouring the hold-while-stalled rule
        held = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!held) begin
                cur = mk($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0,
                         3'($urandom_range(0, 4)), 5'($urandom), $urandom, $urandom,
                         1'b0, 3'($urandom), 5'd0, 5'd0);
                cur.pc4 = $urandom;
                cur.im  = $urandom;
            end
            cur.rv = $urandom_range(0, 2) != 0;
            cur.a1 = ($urandom_range(0, 2) == 0) ? cur.rd : 5'($urandom);
            cur.a2 = ($urandom_range(0, 2) == 0) ? cur.rd : 5'($urandom);
            step(cur);
            held = cur.v && cur.rw && (cur.src == SRC_MEM) && !cur.rv;
        end

        // Reset while a load is stalled
        step(mk(1, 1, SRC_MEM, 5, 32'h0, 32'h1111_2222, 0, 3'b010, 5, 7));
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        rs1_addr = 5; rs2_addr = 7;
        #1 check_reset_outputs("midreset");
        wb_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        step(mk(0, 0, SRC_ALU, 0, 0, 0, 1, 0, 5, 7));

        // Counter wrap
        go_idle();
        force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret;
        m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        step(mk(1, 0, SRC_ALU, 4, 32'h9, 0, 1, 0, 4, 0));
        step(mk(0, 0, SRC_ALU, 0, 0, 0, 1, 0, 4, 0));

        go_idle();
        #2;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expected records left, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
